// File: rtl/synth_pkg.sv
// Shared definitions for the oscillator/waveform blocks.
//   wave_mode_t : output waveform selector (2 bits)
//   DUTY_HALF   : 50 % duty threshold for the default 8-bit duty compare
package synth_pkg;

    typedef enum logic [1:0] {
        SAW_UP   = 2'd0,
        SAW_DOWN = 2'd1,
        TRIANGLE = 2'd2,
        SQUARE   = 2'd3
    } wave_mode_t;

    localparam int           DUTY_W_DEFAULT = 8;
    localparam logic [7:0]   DUTY_HALF      = 8'h80;

endpackage

// File: rtl/wave_shaper.sv
// Combinational phase-to-sample mapper.
//   phase_next : P-bit oscillator phase to be converted
//   mode       : waveform selector
//   duty       : square-wave threshold, compared against the top D phase bits
//   sample     : N-bit output; for N > P the P-bit value is left-justified and
//                the low bits replicate its LSB so full scale is all ones
module wave_shaper
    import synth_pkg::*;
#(
    parameter int P = 16,
    parameter int N = 11,
    parameter int D = 8
) (
    input  logic [P-1:0] phase_next,
    input  wave_mode_t   mode,
    input  logic [D-1:0] duty,
    output logic [N-1:0] sample
);

    logic [P-1:0] dbl;
    logic [P-1:0] tri_p;
    logic [N-1:0] up_n;
    logic [N-1:0] tri_n;
    logic         sq_high;

    assign dbl     = phase_next << 1;
    // Fold the upper half of the cycle back down so the ramp peaks at mid-phase.
    assign tri_p   = phase_next[P-1] ? ~dbl : dbl;
    assign sq_high = (phase_next[P-1 -: D] < duty);

    generate
        if (N <= P) begin : g_narrow
            assign up_n  = N'(phase_next >> (P - N));
            assign tri_n = N'(tri_p >> (P - N));
        end else begin : g_wide
            assign up_n  = {phase_next, {(N - P){phase_next[0]}}};
            assign tri_n = {tri_p, {(N - P){tri_p[0]}}};
        end
    endgenerate

    always_comb begin
        sample = '0;
        case (mode)
            SAW_UP:   sample = up_n;
            SAW_DOWN: sample = ~up_n;
            TRIANGLE: sample = tri_n;
            SQUARE:   sample = sq_high ? {N{1'b1}} : {N{1'b0}};
            default:  sample = up_n;
        endcase
    end

endmodule

// File: rtl/multimode_wave_generator.sv
// Per-channel oscillator: phase accumulator plus selectable waveform output.
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : channel active; when low phase holds and shadows track inputs
//   sample_en     : strobe that advances phase and emits one sample
//   retrig        : restart phase at 0 and load settings immediately
//   step/mode/duty: tuning word, waveform select, square threshold
//   sample        : registered waveform sample
//   sample_valid  : one-cycle pulse per emitted sample
//   wrap          : set with sample_valid when the phase overflowed
// Settings are shadowed and only taken up at phase wrap, retrig or while
// disabled, so a running channel never changes shape mid-cycle.
module multimode_wave_generator
    import synth_pkg::*;
#(
    parameter int P = 16,
    parameter int N = 11,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         sample_en,
    input  logic         retrig,
    input  logic [P-1:0] step,
    input  wave_mode_t   mode,
    input  logic [D-1:0] duty,
    output logic [N-1:0] sample,
    output logic         sample_valid,
    output logic         wrap
);

    localparam logic [D-1:0] DUTY_RST = {1'b1, {(D - 1){1'b0}}};

    logic [P-1:0] phase;
    logic [P-1:0] step_s;
    wave_mode_t   mode_s;
    logic [D-1:0] duty_s;

    logic [P:0]   sum;
    logic         carry;
    logic [P-1:0] phase_next;
    wave_mode_t   mode_eff;
    logic [D-1:0] duty_eff;
    logic [N-1:0] shaped;

    assign sum        = {1'b0, phase} + {1'b0, step_s};
    assign carry      = sum[P];
    assign phase_next = sum[P-1:0];
    // On the wrap sample the new shape is already visible; the new step only
    // affects the following advance because this sum used the old one.
    assign mode_eff   = carry ? mode : mode_s;
    assign duty_eff   = carry ? duty : duty_s;

    wave_shaper #(.P(P), .N(N), .D(D)) u_shaper (
        .phase_next (phase_next),
        .mode       (mode_eff),
        .duty       (duty_eff),
        .sample     (shaped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= '0;
            step_s       <= '0;
            mode_s       <= SAW_UP;
            duty_s       <= DUTY_RST;
            sample       <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else if (retrig) begin
            phase        <= '0;
            step_s       <= step;
            mode_s       <= mode;
            duty_s       <= duty;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else if (!enable) begin
            step_s       <= step;
            mode_s       <= mode;
            duty_s       <= duty;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else if (sample_en) begin
            phase        <= phase_next;
            sample       <= shaped;
            sample_valid <= 1'b1;
            wrap         <= carry;
            if (carry) begin
                step_s <= step;
                mode_s <= mode;
                duty_s <= duty;
            end
        end else begin
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multimode_wave_generator.sv
module tb_multimode_wave_generator;
    import synth_pkg::*;

    localparam int P = 16;
    localparam int N = 11;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         sample_en = 1'b0;
    logic         retrig = 1'b0;
    logic [P-1:0] step = '0;
    wave_mode_t   mode = SAW_UP;
    logic [D-1:0] duty = 8'h80;
    logic [N-1:0] sample;
    logic         sample_valid;
    logic         wrap;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state (plain integers)
    int m_phase, m_step_s, m_mode_s, m_duty_s, m_sample, m_valid, m_wrap;

    multimode_wave_generator #(.P(P), .N(N), .D(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_en    (sample_en),
        .retrig       (retrig),
        .step         (step),
        .mode         (mode),
        .duty         (duty),
        .sample       (sample),
        .sample_valid (sample_valid),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wave(input int x, input int md, input int dt);
        int up, t;
        up = x / 32;                       // top 11 of 16 bits
        case (md)
            0: return up;
            1: return 2047 - up;
            2: begin
                if (x < 32768) t = 2 * x;
                else           t = 65535 - ((2 * x) % 65536);
                return t / 32;
            end
            default: return ((x / 256) < dt) ? 2047 : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_step_s = 0; m_mode_s = 0; m_duty_s = 128;
        m_sample = 0; m_valid = 0; m_wrap = 0;
    endtask

    task automatic model_edge(input int en, input int se, input int rt,
                              input int st, input int md, input int dt);
        int s;
        if (rt != 0) begin
            m_phase = 0; m_step_s = st; m_mode_s = md; m_duty_s = dt;
            m_valid = 0; m_wrap = 0;
        end else if (en == 0) begin
            m_step_s = st; m_mode_s = md; m_duty_s = dt;
            m_valid = 0; m_wrap = 0;
        end else if (se != 0) begin
            s = m_phase + m_step_s;
            m_phase = s % 65536;
            m_wrap = (s >= 65536) ? 1 : 0;
            if (m_wrap != 0) begin
                m_step_s = st; m_mode_s = md; m_duty_s = dt;
            end
            m_sample = wave(m_phase, m_mode_s, m_duty_s);
            m_valid = 1;
        end else begin
            m_valid = 0; m_wrap = 0;
        end
    endtask

    // Drive one cycle of inputs, clock, and compare outputs against the model.
    task automatic cycle(input int en, input int se, input int rt,
                         input int st, input int md, input int dt);
        enable = en[0]; sample_en = se[0]; retrig = rt[0];
        step = st[P-1:0]; mode = wave_mode_t'(md[1:0]); duty = dt[D-1:0];
        @(posedge clk);
        model_edge(en, se, rt, st, md, dt);
        #1;
        chk("model_sample", int'(sample), m_sample);
        chk("model_valid", int'(sample_valid), m_valid);
        chk("model_wrap", int'(wrap), m_wrap);
        enable = 1'b1; sample_en = 1'b0; retrig = 1'b0;
    endtask

    task automatic strobe(input int st, input int md, input int dt);
        cycle(1, 1, 0, st, md, dt);
    endtask

    task automatic ramp_from_reset();
        cycle(0, 0, 0, 'h1000, 0, 'h80);   // load shadows while disabled
        for (int k = 1; k <= 16; k++) begin
            strobe('h1000, 0, 'h80);
            chk("ramp_sample", int'(sample), (k * 'h80) % 'h800);
            chk("ramp_wrap", int'(wrap), (k == 16) ? 1 : 0);
            cycle(1, 0, 0, 'h1000, 0, 'h80);
            chk("ramp_valid_drop", int'(sample_valid), 0);
        end
    endtask

    initial begin
        int en, se, rt, st, md, dt;
        model_reset();
        #12;
        chk("rst_sample", int'(sample), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_wrap", int'(wrap), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        ramp_from_reset();

        // SAW_DOWN
        cycle(0, 0, 0, 'h1000, 1, 'h80);
        strobe('h1000, 1, 'h80);
        chk("sawdown", int'(sample), 'h77F);

        // TRIANGLE
        cycle(1, 0, 1, 'h4000, 2, 'h80);
        strobe('h4000, 2, 'h80); chk("tri0", int'(sample), 'h400);
        strobe('h4000, 2, 'h80); chk("tri1", int'(sample), 'h7FF);
        strobe('h4000, 2, 'h80); chk("tri2", int'(sample), 'h3FF);
        strobe('h4000, 2, 'h80); chk("tri3", int'(sample), 'h000);
        chk("tri3_wrap", int'(wrap), 1);

        // SQUARE
        cycle(1, 0, 1, 'h1000, 3, 'h40);
        strobe('h1000, 3, 'h40); chk("sq1", int'(sample), 'h7FF);
        strobe('h1000, 3, 'h40); chk("sq2", int'(sample), 'h7FF);
        strobe('h1000, 3, 'h40); chk("sq3", int'(sample), 'h7FF);
        strobe('h1000, 3, 'h40); chk("sq4", int'(sample), 'h000);
        cycle(1, 0, 1, 'h1000, 3, 'h00);
        for (int k = 0; k < 4; k++) begin
            strobe('h1000, 3, 'h00);
            chk("sq_duty0", int'(sample), 0);
        end

        // Deferred change
        cycle(1, 0, 1, 'h1000, 0, 'h80);
        for (int k = 0; k < 3; k++) strobe('h1000, 0, 'h80);
        for (int k = 4; k <= 15; k++) begin
            strobe('h2000, 1, 'h80);
            chk("defer_hold", int'(sample), k * 'h80);
            chk("defer_nowrap", int'(wrap), 0);
        end
        strobe('h2000, 1, 'h80);
        chk("defer_wrap_sample", int'(sample), 'h7FF);
        chk("defer_wrap", int'(wrap), 1);
        strobe('h2000, 1, 'h80);
        chk("defer_newstep", int'(sample), 'h6FF);

        // Retrig colliding with sample_en
        cycle(1, 0, 1, 'h1000, 0, 'h80);
        for (int k = 0; k < 9; k++) strobe('h1000, 0, 'h80);
        chk("pre_retrig", int'(sample), 'h480);
        cycle(1, 1, 1, 'h3000, 0, 'h80);
        chk("retrig_novalid", int'(sample_valid), 0);
        strobe('h3000, 0, 'h80);
        chk("retrig_first", int'(sample), 'h180);

        // step_s = 0 freezes phase
        cycle(1, 0, 1, 0, 0, 'h80);
        for (int k = 0; k < 3; k++) begin
            strobe('h1234, 0, 'h80);
            chk("step0_sample", int'(sample), 0);
            chk("step0_valid", int'(sample_valid), 1);
        end

        // Async reset mid-stream
        cycle(1, 0, 1, 'h1000, 0, 'h80);
        for (int k = 0; k < 5; k++) strobe('h1000, 0, 'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sample", int'(sample), 0);
        chk("arst_valid", int'(sample_valid), 0);
        chk("arst_wrap", int'(wrap), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ramp_from_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0) ? 1 : 0;
            se = $urandom_range(0, 1);
            rt = ($urandom_range(0, 49) == 0) ? 1 : 0;
            case ($urandom_range(0, 3))
                0: st = 0;
                1: st = $urandom_range(0, 'h0FFF);
                2: st = $urandom_range('h1000, 'h6000);
                default: st = $urandom_range(0, 'hFFFF);
            endcase
            md = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: dt = 0;
                1: dt = 'hFF;
                default: dt = $urandom_range(0, 'hFF);
            endcase
            cycle(en, se, rt, st, md, dt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multimode_wave_generator.md
Name: multimode_wave_generator

Overview:
- Per-channel oscillator core that replaces the fixed combinational sawtooth expander.
- Owns its own phase accumulator, advanced on a sample strobe by a programmable step (tuning word).
- Output is selectable: rising saw, falling saw, triangle, or variable-duty square.
- Mode, step and duty changes are shadowed and applied only at phase wrap (or on retrigger), so a channel never emits a mid-cycle glitch.

Parameters:
- P, 16, phase accumulator width in bits (also the step width).
- N, 11, output sample width in bits; N > P is legal (see width rules).
- D, 8, duty-compare width in bits; D <= P.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  channel active; when low, phase holds and shadows track inputs
- sample_en  input  1  one-cycle strobe: advance phase and emit one sample
- retrig  input  1  note-on: phase := 0 and load shadows immediately
- step  input  P  phase increment per sample_en
- mode  input  2  wave_mode_t: 0 SAW_UP, 1 SAW_DOWN, 2 TRIANGLE, 3 SQUARE
- duty  input  D  square high threshold on top D phase bits
- sample  output  N  registered waveform sample
- sample_valid  output  1  one-cycle pulse, new sample present
- wrap  output  1  qualifies sample_valid: the accumulation for this sample overflowed

Behaviour:
- Reset (async, rst_n=0) clears:
  - phase = 0, sample = 0, sample_valid = 0, wrap = 0.
  - Shadows: step_s = 0, mode_s = SAW_UP, duty_s = 2^(D-1).
- Priority per clock edge: retrig > (enable & sample_en) > idle.
- retrig:
  - Sets phase := 0 and loads step_s/mode_s/duty_s from the inputs.
  - Sets sample_valid := 0 and wrap := 0, even if sample_en is also high.
- enable=0:
  - phase and sample hold; sample_valid = 0.
  - Shadows load from the inputs every cycle.
- Advance (enable=1, sample_en=1, no retrig):
  - sum = phase + step_s, computed at P+1 bits; phase := sum[P-1:0].
  - c = sum[P] (the carry).
  - If c=1, shadows load from the inputs on this edge, and the emitted sample is computed with the new mode_s/duty_s. The new step_s takes effect from the next advance.
  - sample := f(phase_next, mode_eff); sample_valid := 1; wrap := c.
  - Latency: one cycle from sample_en to sample_valid. Back-to-back strobes give back-to-back samples.
- step_s = 0: phase is frozen, samples keep being emitted, wrap never asserts.
- Wave functions, with x = phase_next:
  - SAW_UP: top N bits of x.
  - SAW_DOWN: bitwise inverse of the SAW_UP value.
  - TRIANGLE: t = x[P-1] ? ~(x<<1) : (x<<1), computed at P bits; output is the top N bits of t.
  - SQUARE: all ones if x[P-1:P-D] < duty_s, else 0. duty_s = 0 gives constant 0.
- Width rule for N > P: the output is the P-bit value left-justified, with the low N-P bits filled by copies of its LSB, so full scale maps to all ones.
- All arithmetic is unsigned, and phase wraps modulo 2^P.

Decomposition:
- Shared package synth_pkg: typedef enum logic [1:0] wave_mode_t {SAW_UP, SAW_DOWN, TRIANGLE, SQUARE}; constant DUTY_HALF.
- Sub-module wave_shaper: purely combinational. Inputs are phase_next, mode and duty; output is the N-bit sample. It contains the width-extension rule so other generators can reuse it.
- The accumulator, shadow registers and output register stay in the top module.

Test Plan:
Defaults P=16, N=11, D=8.
- Reset and ramp: hold rst_n low, release, enable=1, step=0x1000, SAW_UP, pulse sample_en 16 times.
  - Required: samples 0x080, 0x100, …, 0x780, then 0x000 with wrap=1 on the 16th.
  - Required: sample_valid exactly one cycle after each strobe.
- SAW_DOWN and TRIANGLE:
  - SAW_DOWN: after one strobe, sample = 0x77F.
  - TRIANGLE, step=0x4000: samples 0x400, 0x7FF, 0x3FF, 0x000; the last has wrap=1.
- SQUARE: duty=0x40, step=0x1000.
  - Phases 0x1000–0x3000 give 0x7FF; phase 0x4000 gives 0x000.
  - duty=0x00 gives constant 0x000.
- Deferred change: while at phase 0x3000 in SAW_UP, drive mode=SAW_DOWN and step=0x2000.
  - Required: samples stay SAW_UP (0x200, …) until the wrap sample. The wrap sample is 0x7FF with wrap=1.
  - Required: the next sample is 0x6FF, reflecting the new step.
- Retrig collision: retrig and sample_en high together at phase 0x9000.
  - Required: phase = 0, no sample_valid, new settings loaded.
  - Required: the next strobe yields the first-step sample.
- Async reset mid-stream: drop rst_n between clock edges.
  - Required: sample, sample_valid and wrap go to 0 immediately without waiting for a clock edge.
  - Required: after release, the first strobe behaves as in scenario 1.
